// File: rtl/leiwand_rv32_bus_decoder_pkg.sv
// Shared types and helpers for the leiwand_rv32 memory bus decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package leiwand_rv32_bus_decoder_pkg;

    // Decoder transaction states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Wait cycles before an unresponsive slave is given up on.
    localparam int DEFAULT_TIMEOUT = 255;

    // Width of a slave index; a single slave still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the wait counter; TIMEOUT=0 still gets one bit.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/leiwand_rv32_addr_match.sv
// Region compare plus priority encoder: maps an address onto one slave index.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   addr  in   XLEN    byte address to decode
//   hit   out  1       address falls inside at least one enabled region
//   sel   out  SEL_W   lowest-index matching region (0 when no hit)
module leiwand_rv32_addr_match
    import leiwand_rv32_bus_decoder_pkg::*;
#(
    parameter int                           XLEN       = 32,
    parameter int                           NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*XLEN-1:0]   SLV_BASE   = {32'h80000000, 32'h00000000},
    parameter logic [NUM_SLAVES*XLEN-1:0]   SLV_SIZE   = {32'h00004000, 32'h00000100},
    parameter int                           SEL_W      = idx_width(NUM_SLAVES)
) (
    input  logic [XLEN-1:0]  addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    logic [NUM_SLAVES-1:0] match;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_region
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] size;
        logic [XLEN-1:0] offset;

        assign base   = SLV_BASE[i*XLEN +: XLEN];
        assign size   = SLV_SIZE[i*XLEN +: XLEN];
        // Wrapping subtraction keeps regions ending at the top of the
        // address space correct (base+size would overflow to zero).
        assign offset = addr - base;
        assign match[i] = (size != '0) && (offset < size);
    end

    // Walk from the highest index down so the lowest matching index is
    // the last one written and therefore wins on overlap.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/leiwand_rv32_bus_decoder.sv
// Single-master, N-slave memory bus decoder with unmapped-address and timeout errors.
// Latency: miss -> ready 1 cycle after request; hit -> ready 1 cycle after slave ready (min 2).
// Backpressure: master holds i_mem_valid until o_mem_ready; slave stalls via i_slv_ready up to TIMEOUT.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_mem_valid/addr/wdata/wen        core request (wen==0 is a read)
//   o_mem_ready/err/rdata             one-cycle completion pulse with status and read data
//   o_slv_valid                       one-hot request to the selected slave
//   o_slv_addr/wdata/wen              latched request, shared by all slaves
//   i_slv_ready, i_slv_rdata          per-slave completion and packed read data
module leiwand_rv32_bus_decoder
    import leiwand_rv32_bus_decoder_pkg::*;
#(
    parameter int                           XLEN       = 32,
    parameter int                           NUM_SLAVES = 2,
    // Slave i lives at bits [i*XLEN +: XLEN]: slave 0 = 0x00000000/0x100,
    // slave 1 = 0x80000000/0x4000 (concatenation lists the highest index first).
    parameter logic [NUM_SLAVES*XLEN-1:0]   SLV_BASE   = {32'h80000000, 32'h00000000},
    parameter logic [NUM_SLAVES*XLEN-1:0]   SLV_SIZE   = {32'h00004000, 32'h00000100},
    parameter int                           TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_mem_valid,
    output logic                       o_mem_ready,
    output logic                       o_mem_err,
    input  logic [XLEN-1:0]            i_mem_addr,
    input  logic [XLEN-1:0]            i_mem_wdata,
    input  logic [XLEN/8-1:0]          i_mem_wen,
    output logic [XLEN-1:0]            o_mem_rdata,
    output logic [NUM_SLAVES-1:0]      o_slv_valid,
    input  logic [NUM_SLAVES-1:0]      i_slv_ready,
    output logic [XLEN-1:0]            o_slv_addr,
    output logic [XLEN-1:0]            o_slv_wdata,
    output logic [XLEN/8-1:0]          o_slv_wen,
    input  logic [NUM_SLAVES*XLEN-1:0] i_slv_rdata
);

    localparam int SEL_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;

    logic                    mem_ready_d;
    logic                    mem_err_d;
    logic [XLEN-1:0]         mem_rdata_d;
    logic [NUM_SLAVES-1:0]   slv_valid_d;
    logic [XLEN-1:0]         slv_addr_d;
    logic [XLEN-1:0]         slv_wdata_d;
    logic [XLEN/8-1:0]       slv_wen_d;

    logic                    dec_hit;
    logic [SEL_W-1:0]        dec_sel;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic                    sel_ready;
    logic [XLEN-1:0]         sel_rdata;
    logic                    timeout_hit;

    leiwand_rv32_addr_match #(
        .XLEN       (XLEN),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_SIZE   (SLV_SIZE),
        .SEL_W      (SEL_W)
    ) u_addr_match (
        .addr (i_mem_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec_onehot[i] = (dec_sel == SEL_W'(i));
        end
    end

    // Only the latched slave may complete the access; other readies are noise.
    assign sel_ready = i_slv_ready[sel_q];
    assign sel_rdata = i_slv_rdata[sel_q*XLEN +: XLEN];

    // cnt_q counts completed wait cycles, so TIMEOUT-1 means this is the
    // TIMEOUT-th cycle with o_slv_valid high.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_rdata_d = o_mem_rdata;
        slv_valid_d = '0;
        slv_addr_d  = o_slv_addr;
        slv_wdata_d = o_slv_wdata;
        slv_wen_d   = o_slv_wen;

        case (state_q)
            ST_IDLE: begin
                if (i_mem_valid) begin
                    slv_addr_d  = i_mem_addr;
                    slv_wdata_d = i_mem_wdata;
                    slv_wen_d   = i_mem_wen;
                    sel_d       = dec_sel;
                    cnt_d       = '0;
                    if (dec_hit) begin
                        state_d     = ST_ACCESS;
                        slv_valid_d = dec_onehot;
                    end else begin
                        state_d     = ST_RESP;
                        mem_ready_d = 1'b1;
                        mem_err_d   = 1'b1;
                        mem_rdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready is checked first so it wins over a same-cycle timeout.
                if (sel_ready) begin
                    state_d     = ST_RESP;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = sel_rdata;
                end else if (timeout_hit) begin
                    state_d     = ST_RESP;
                    mem_ready_d = 1'b1;
                    mem_err_d   = 1'b1;
                    mem_rdata_d = '0;
                end else begin
                    slv_valid_d = o_slv_valid;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            o_mem_ready <= 1'b0;
            o_mem_err   <= 1'b0;
            o_mem_rdata <= '0;
            o_slv_valid <= '0;
            o_slv_addr  <= '0;
            o_slv_wdata <= '0;
            o_slv_wen   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            o_mem_ready <= mem_ready_d;
            o_mem_err   <= mem_err_d;
            o_mem_rdata <= mem_rdata_d;
            o_slv_valid <= slv_valid_d;
            o_slv_addr  <= slv_addr_d;
            o_slv_wdata <= slv_wdata_d;
            o_slv_wen   <= slv_wen_d;
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_bus_decoder.sv
// Self-checking bench for leiwand_rv32_bus_decoder: randomized requests, region-map reference model, scoreboard.
// Latency: n/a.
// Backpressure: slave responder stalls each access by a chosen number of cycles (or forever).
module tb_leiwand_rv32_bus_decoder;

    localparam int NS = 5;
    localparam int TO = 4;
    localparam int NEVER = 99;

    // Map: 0 low 256 B, 1 at 0x80000000, 2 overlapping upper half of 1,
    // 3 touching the top of the address space, 4 disabled (size 0).
    localparam logic [NS*32-1:0] BASE = {32'h40000000, 32'hFFFFFF00, 32'h80002000, 32'h80000000, 32'h00000000};
    localparam logic [NS*32-1:0] SIZE = {32'h00000000, 32'h00000100, 32'h00004000, 32'h00004000, 32'h00000100};

    longint unsigned m_base [NS] = '{64'h0000_0000, 64'h8000_0000, 64'h8000_2000, 64'hFFFF_FF00, 64'h4000_0000};
    longint unsigned m_size [NS] = '{64'h100, 64'h4000, 64'h4000, 64'h100, 64'h0};

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_valid, mem_ready, mem_err;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_wen, slv_wen;
    logic [31:0]       slv_addr, slv_wdata;
    logic [NS-1:0]     slv_valid;
    logic [NS-1:0]     slv_ready = '0;
    logic [NS*32-1:0]  slv_rdata = '0;

    always #5 clk = ~clk;

    leiwand_rv32_bus_decoder #(
        .XLEN       (32),
        .NUM_SLAVES (NS),
        .SLV_BASE   (BASE),
        .SLV_SIZE   (SIZE),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_valid (mem_valid),
        .o_mem_ready (mem_ready),
        .o_mem_err   (mem_err),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .i_mem_wen   (mem_wen),
        .o_mem_rdata (mem_rdata),
        .o_slv_valid (slv_valid),
        .i_slv_ready (slv_ready),
        .o_slv_addr  (slv_addr),
        .o_slv_wdata (slv_wdata),
        .o_slv_wen   (slv_wen),
        .i_slv_rdata (slv_rdata)
    );

    typedef struct {
        int            t;
        int            due;
        bit            err;
        logic [31:0]   rdata;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wen;
        logic [NS-1:0] onehot;
    } exp_t;

    exp_t sb [$];
    exp_t mh;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference decode: plain 64-bit interval test, first listed region wins.
    function automatic void ref_decode(input logic [31:0] a, output bit hit, output int idx);
        longint unsigned av;
        av  = {32'b0, a};
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && m_size[i] != 0 && av >= m_base[i] && av < m_base[i] + m_size[i]) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    // Slave responder: the selected slave answers on its dly-th wait cycle,
    // unselected slaves toggle ready randomly, rdata is random otherwise.
    int          rdy_delay = 0;
    logic [31:0] rsp_data  = '0;
    int          acc_cnt   = 0;
    logic [NS-1:0] noise;

    always @(posedge clk) begin
        #1;
        noise = NS'($urandom);
        for (int i = 0; i < NS; i++) slv_rdata[i*32 +: 32] = $urandom;
        if (slv_valid != '0) begin
            acc_cnt++;
            if (acc_cnt == rdy_delay) begin
                slv_ready = slv_valid | (noise & ~slv_valid);
                for (int i = 0; i < NS; i++)
                    if (slv_valid[i]) slv_rdata[i*32 +: 32] = rsp_data;
            end else begin
                slv_ready = noise & ~slv_valid;
            end
        end else begin
            acc_cnt   = 0;
            slv_ready = noise;
        end
    end

    // Called just after a rising edge: that cycle becomes T.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input int dly, input logic [31:0] d);
        exp_t e;
        bit   hit;
        int   idx;
        ref_decode(a, hit, idx);
        e.t      = cyc;
        e.addr   = a;
        e.wdata  = wd;
        e.wen    = we;
        e.onehot = hit ? (NS'(1) << idx) : '0;
        if (!hit) begin
            e.due = cyc + 1;  e.err = 1'b1; e.rdata = '0;
        end else if (dly > TO) begin
            e.due = cyc + TO + 1; e.err = 1'b1; e.rdata = '0;
        end else begin
            e.due = cyc + dly + 1; e.err = 1'b0; e.rdata = d;
        end
        sb.push_back(e);
        rdy_delay = dly;
        rsp_data  = d;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wen   = we;
        mem_valid = 1'b1;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL txn_done: no o_mem_ready within 40 cycles, required one pulse");
            sb.delete();
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input int dly, input logic [31:0] d);
        issue(a, wd, we, dly, d);
        wait_done();
    endtask

    // Monitor: checks every cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (sb.size() == 0) begin
                chk("idle_slv_valid", 32'(slv_valid), 32'h0);
                chk("idle_mem_ready", 32'(mem_ready), 32'h0);
            end else begin
                mh = sb[0];
                chk("slv_valid", 32'(slv_valid),
                    (cyc > mh.t && cyc < mh.due) ? 32'(mh.onehot) : 32'h0);
                if (slv_valid != '0) begin
                    chk("slv_addr",  slv_addr,  mh.addr);
                    chk("slv_wdata", slv_wdata, mh.wdata);
                    chk("slv_wen",   32'(slv_wen), 32'(mh.wen));
                end
                if (mem_ready) begin
                    chk("resp_cycle", cyc, mh.due);
                    chk("mem_err",   32'(mem_err), 32'(mh.err));
                    chk("mem_rdata", mem_rdata, mh.rdata);
                    void'(sb.pop_front());
                end else if (cyc == mh.due) begin
                    chk("mem_ready_at_due", 32'(mem_ready), 32'h1);
                end
            end
        end
    end

    logic [31:0] bnd [7] = '{32'h0000_0100, 32'h0000_00FF, 32'h7FFF_FFFF, 32'h8000_5FFF,
                             32'h8000_6000, 32'hFFFF_FEFF, 32'h4000_0000};

    initial begin
        logic [31:0] a;
        int          dly;
        int          c;
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_mem_err",   32'(mem_err),   32'h0);
        chk("rst_mem_rdata", mem_rdata,      32'h0);
        chk("rst_slv_valid", 32'(slv_valid), 32'h0);
        chk("rst_slv_addr",  slv_addr,       32'h0);
        chk("rst_slv_wdata", slv_wdata,      32'h0);
        chk("rst_slv_wen",   32'(slv_wen),   32'h0);
        mon_en = 1'b1;

        txn(32'h8000_0010, 32'h0,        4'h0, 2,     32'hDEADBEEF);  // read slave 1
        txn(32'h0000_0004, 32'h12345678, 4'hF, 1,     32'h0BAD_F00D); // write slave 0
        txn(32'h4000_0000, 32'h0,        4'h0, 1,     32'h1111_1111); // unmapped / disabled region
        txn(32'h8000_0020, 32'h0,        4'h0, NEVER, 32'h2222_2222); // timeout
        txn(32'h8000_2000, 32'h0,        4'h0, TO,    32'h3333_3333); // overlap, ready on timeout cycle
        txn(32'h8000_4000, 32'hA5A5A5A5, 4'h3, 2,     32'h4444_4444); // slave 2 only
        txn(32'hFFFF_FFFC, 32'h0,        4'h0, 3,     32'h5555_5555); // top of address space
        txn(32'h0000_0100, 32'h0,        4'h0, 1,     32'h6666_6666); // one past slave 0
        txn(32'h0000_00FF, 32'h0,        4'h0, 1,     32'h7777_7777); // last byte of slave 0

        // Reset in the middle of an access that would otherwise time out.
        issue(32'h8000_0100, 32'h0, 4'h0, NEVER, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_valid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_slv_valid", 32'(slv_valid), 32'h0);
        chk("abort_mem_ready", 32'(mem_ready), 32'h0);
        chk("abort_slv_addr",  slv_addr,       32'h0);
        repeat (TO + 2) @(posedge clk);
        #1;
        txn(32'h0000_0010, 32'h0, 4'h0, 1, 32'hCAFE_0001);

        for (int n = 0; n < 80; n++) begin
            c = $urandom_range(0, 7);
            case (c)
                0:       a = 32'h0000_0000 + $urandom_range(0, 255);
                1:       a = 32'h8000_0000 + $urandom_range(0, 32'h3FFF);
                2:       a = 32'h8000_2000 + $urandom_range(0, 32'h3FFF);
                3:       a = 32'hFFFF_FF00 + $urandom_range(0, 255);
                4:       a = bnd[$urandom_range(0, 6)];
                7:       a = 32'h4000_0000 + $urandom_range(0, 32'hFFFF);
                default: a = $urandom;
            endcase
            dly = $urandom_range(0, 5);
            if (dly == 0) dly = NEVER;
            issue(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, dly, $urandom);
            wait_done();
            if ($urandom_range(0, 1) != 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
